seq_twos_comp: RTL and testbench
================================

Name: seq_twos_comp

Overview:
- Parametrised, multi-cycle two's-complement unit; the next generation of the team's fixed 6-bit combinational negator.
- Takes one WIDTH-bit operand per transaction over a valid/ready handshake and produces pass, negate or absolute value.
- Processes the operand CHUNK bits per cycle, LSB first, with a registered ripple carry. Area trades against latency for wide operands.
- Sits between the operand register file and the Logic-Unit adder/ALU datapath.

Parameters:
- WIDTH, 6, operand and result width in bits; must be >= 2.
- CHUNK, 2, bits processed per cycle; must divide WIDTH exactly. CHUNK = WIDTH gives single-pass operation.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand and mode are valid.
- in_ready  out  1  unit can accept an operand.
- x  in  WIDTH  operand, two's complement.
- mode  in  2  00 pass, 01 negate, 10 abs, 11 reserved (treated as pass).
- out_valid  out  1  y and ovf are valid.
- out_ready  in  1  consumer accepts the result.
- y  out  WIDTH  result.
- ovf  out  1  set when negate/abs is applied to the most-negative value.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, in_ready=1, out_valid=0, y=0, ovf=0, chunk counter=0, carry=0.
  - rst overrides everything, including mid-RUN and DONE. Any in-flight operand is discarded and no result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - in_valid=1 at an edge: latch x and mode.
  - Effective invert flag: inv = (mode==01) | (mode==10 & x[WIDTH-1]).
  - Set carry=inv, counter=0, clear the result register, go to RUN.
- RUN: in_ready=0, out_valid=0.
  - Each edge handles chunk k = counter, bits [k*CHUNK +: CHUNK].
  - Operation: y_chunk = (x_chunk XOR {CHUNK{inv}}) + carry. The chunk sum is written into the result and the chunk carry-out is registered for the next chunk.
  - On the edge handling the last chunk (counter = WIDTH/CHUNK-1): go to DONE.
- Arithmetic and width rules:
  - Result is modulo 2^WIDTH; the final carry-out is discarded.
  - ovf = inv & (x == {1'b1,{WIDTH-1{1'b0}}}). In that case y = x (wrap).
  - ovf is 0 for pass and for every other operand.
- Latency: for an accept at edge E, out_valid rises after edge E+WIDTH/CHUNK. Example: WIDTH=6, CHUNK=2 gives 3 cycles.
- DONE: out_valid=1, in_ready=0.
  - y and ovf stay stable until the edge where out_ready=1. At that edge, go to IDLE and drop out_valid.
  - No accept occurs in the same cycle as a result handoff. Throughput is one operand per WIDTH/CHUNK+2 cycles.
- Input stability: in_valid asserted while in_ready=0 is ignored. x and mode are captured only at accept, so changes after accept have no effect.
- out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Package twos_comp_pkg holds:
  - mode constants MODE_PASS, MODE_NEG, MODE_ABS, MODE_RSVD;
  - state enum IDLE/RUN/DONE;
  - a function computing the most-negative pattern for WIDTH.
- One sub-module, twos_comp_chunk: combinational CHUNK-bit conditional-invert plus carry-in adder.
  - Ports: a[CHUNK], inv, cin, s[CHUNK], cout.
  - Built from the team's FullAdder cells, instantiated once in the parent.

Test Plan (WIDTH=6, CHUNK=2 unless stated):
- Negate: x=6'd5, mode=01 → y=6'b111011, ovf=0, out_valid high exactly 3 cycles after the accept edge. Negate x=0 → y=0, ovf=0 (carry-out discarded).
- Abs: x=6'b111011, mode=10 → y=6'b000101. Abs of x=6'b000101 → y=6'b000101. Pass, and mode=11, with x=6'b101010 → y=6'b101010. All cases ovf=0.
- Overflow: x=6'b100000 with mode=01 and with mode=10 → y=6'b100000, ovf=1.
- Backpressure: out_ready held low 5 cycles after out_valid → y and ovf stable, in_ready=0, and a new in_valid pulse is ignored. On out_ready=1 → IDLE next cycle, in_ready=1.
- Reset mid-operation: rst=1 on the 2nd RUN cycle → next cycle out_valid=0, in_ready=1, y=0, ovf=0, and no stale result appears afterwards.
- Parameter sweep: WIDTH=8 with CHUNK=1, 4 and 8, exhaustive x × all modes vs a reference model → all results match. Latencies are 8, 2 and 1 cycles respectively.

Source files
------------

// File: rtl/twos_comp_pkg.sv
// twos_comp_pkg: shared mode codes, FSM states and helpers for seq_twos_comp
package twos_comp_pkg;
   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_NEG  = 2'b01;
   localparam logic [1:0] MODE_ABS  = 2'b10;
   localparam logic [1:0] MODE_RSVD = 2'b11;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic logic [63:0] most_neg(input int width);
      return 64'd1 << (width - 1);
   endfunction
endpackage

// File: rtl/twos_comp_chunk.sv
// twos_comp_chunk: CHUNK-bit conditional invert plus carry-in ripple adder
// ports: a operand slice, inv invert enable, cin carry in, s sum slice, cout carry out
module twos_comp_chunk #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic             inv,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);
   logic [CHUNK:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      // full-adder cell whose second operand is zero
      logic b;
      assign b = a[i] ^ inv;
      assign s[i] = b ^ c[i];
      assign c[i+1] = b & c[i];
   end
   assign cout = c[CHUNK];
endmodule

// File: rtl/seq_twos_comp.sv
// seq_twos_comp: multi-cycle pass/negate/abs unit, CHUNK bits per cycle LSB first
// ports: clk, rst (sync, active high), in_valid/in_ready + x/mode operand handshake,
//        out_valid/out_ready + y/ovf result handshake
module seq_twos_comp
   import twos_comp_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             ovf
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
   localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));
   state_t state;
   logic [WIDTH-1:0] xr;
   logic [CW-1:0] cnt;
   logic inv, carry, nx_inv, last, cout;
   logic [CHUNK-1:0] s;
   // mode is folded into a single invert flag at accept; pass and reserved both leave it clear
   assign nx_inv = mode == MODE_NEG || (mode == MODE_ABS && x[WIDTH-1]);
   assign last = cnt == CW'(NCH - 1);
   twos_comp_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a(xr[cnt*CHUNK +: CHUNK]),
      .inv(inv),
      .cin(carry),
      .s(s),
      .cout(cout)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         in_ready <= 1'b1;
         out_valid <= 1'b0;
         y <= '0;
         ovf <= 1'b0;
         cnt <= '0;
         carry <= 1'b0;
         inv <= 1'b0;
         xr <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               xr <= x;
               inv <= nx_inv;
               carry <= nx_inv;
               cnt <= '0;
               y <= '0;
               ovf <= 1'b0;
               in_ready <= 1'b0;
               state <= RUN;
            end
            RUN: begin
               y[cnt*CHUNK +: CHUNK] <= s;
               carry <= cout;
               cnt <= last ? '0 : cnt + 1'b1;
               if (last) begin
                  state <= DONE;
                  out_valid <= 1'b1;
                  ovf <= inv && xr == MOST_NEG;
               end
            end
            DONE: if (out_ready) begin
               state <= IDLE;
               out_valid <= 1'b0;
               in_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_twos_comp.sv
// tb_seq_twos_comp: table vectors, handshake corners and WIDTH=8 sweeps for seq_twos_comp
module tb_seq_twos_comp;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic iv[4], ir[4], ov[4], ordy[4], of[4];
   logic [7:0] xs[4], ys[4];
   logic [1:0] ms[4];
   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int W = g == 0 ? 6 : 8;
      localparam int C = g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 4 : 8;
      logic [W-1:0] yw;
      seq_twos_comp #(.WIDTH(W), .CHUNK(C)) u_dut (
         .clk(clk),
         .rst(rst),
         .in_valid(iv[g]),
         .in_ready(ir[g]),
         .x(xs[g][W-1:0]),
         .mode(ms[g]),
         .out_valid(ov[g]),
         .out_ready(ordy[g]),
         .y(yw),
         .ovf(of[g])
      );
      assign ys[g] = 8'(yw);
   end
   typedef struct {
      logic [7:0] y;
      logic       o;
   } exp_t;
   typedef struct {
      logic [5:0] x;
      logic [1:0] m;
      logic [5:0] y;
      logic       o;
   } vec_t;
   exp_t sb[$];
   vec_t tbl[11];
   int checks = 0;
   int passed = 0;
   function automatic int lat_of(input int g);
      return g == 0 ? 3 : g == 1 ? 8 : g == 2 ? 2 : 1;
   endfunction
   function automatic exp_t model(input int w, input logic [7:0] x, input logic [1:0] m);
      exp_t e;
      int mask, xv, neg, inv;
      mask = (1 << w) - 1;
      xv = int'(x) & mask;
      neg = (xv >> (w - 1)) & 1;
      inv = (m == 2'b01 || (m == 2'b10 && neg == 1)) ? 1 : 0;
      e.y = 8'(inv == 1 ? ((~xv + 1) & mask) : xv);
      e.o = inv == 1 && xv == (1 << (w - 1));
      return e;
   endfunction
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a === e) passed++;
      else $display("FAIL %s: got %0h expected %0h", n, a, e);
   endtask
   task automatic xact(input int g, input logic [7:0] x, input logic [1:0] m, input logic [7:0] ey, input logic eo);
      int lat;
      exp_t e;
      lat = 0;
      sb.push_back('{ey, eo});
      xs[g] = x;
      ms[g] = m;
      iv[g] = 1'b1;
      @(posedge clk); #1;
      iv[g] = 1'b0;
      xs[g] = ~x;
      ms[g] = ~m;
      while (!ov[g] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      e = sb.pop_front();
      chk($sformatf("latency g%0d x=%0h m=%0d", g, x, m), lat, lat_of(g));
      chk($sformatf("y g%0d x=%0h m=%0d", g, x, m), ys[g], e.y);
      chk($sformatf("ovf g%0d x=%0h m=%0d", g, x, m), of[g], e.o);
      ordy[g] = 1'b1;
      @(posedge clk); #1;
      ordy[g] = 1'b0;
      chk($sformatf("in_ready after handoff g%0d", g), ir[g], 1);
   endtask
   initial begin
      bit seen;
      tbl[0]  = '{6'd5,       2'b01, 6'b111011, 1'b0};
      tbl[1]  = '{6'd0,       2'b01, 6'd0,      1'b0};
      tbl[2]  = '{6'b111011,  2'b10, 6'b000101, 1'b0};
      tbl[3]  = '{6'b000101,  2'b10, 6'b000101, 1'b0};
      tbl[4]  = '{6'b101010,  2'b00, 6'b101010, 1'b0};
      tbl[5]  = '{6'b101010,  2'b11, 6'b101010, 1'b0};
      tbl[6]  = '{6'b100000,  2'b01, 6'b100000, 1'b1};
      tbl[7]  = '{6'b100000,  2'b10, 6'b100000, 1'b1};
      tbl[8]  = '{6'b100000,  2'b00, 6'b100000, 1'b0};
      tbl[9]  = '{6'b111111,  2'b01, 6'b000001, 1'b0};
      tbl[10] = '{6'b011111,  2'b10, 6'b011111, 1'b0};
      for (int g = 0; g < 4; g++) begin
         iv[g] = 1'b0;
         ordy[g] = 1'b0;
         xs[g] = '0;
         ms[g] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("reset in_ready g%0d", g), ir[g], 1);
         chk($sformatf("reset out_valid g%0d", g), ov[g], 0);
         chk($sformatf("reset y g%0d", g), ys[g], 0);
         chk($sformatf("reset ovf g%0d", g), of[g], 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 11; i++) xact(0, 8'(tbl[i].x), tbl[i].m, 8'(tbl[i].y), tbl[i].o);
      // backpressure: result held for 5 cycles, a stray in_valid must be ignored
      xs[0] = 8'd5;
      ms[0] = 2'b01;
      iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("bp out_valid", ov[0], 1);
      for (int c = 0; c < 5; c++) begin
         iv[0] = c == 1;
         xs[0] = 8'd9;
         ms[0] = 2'b00;
         @(posedge clk); #1;
         chk($sformatf("bp y c%0d", c), ys[0], 8'b00111011);
         chk($sformatf("bp ovf c%0d", c), of[0], 0);
         chk($sformatf("bp in_ready c%0d", c), ir[0], 0);
         chk($sformatf("bp out_valid c%0d", c), ov[0], 1);
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      chk("bp release out_valid", ov[0], 0);
      chk("bp release in_ready", ir[0], 1);
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         seen |= ov[0];
      end
      chk("bp ignored pulse no result", seen, 0);
      // reset during the second RUN cycle discards the operand
      xs[0] = 8'd5;
      ms[0] = 2'b01;
      iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst out_valid", ov[0], 0);
      chk("midrst in_ready", ir[0], 1);
      chk("midrst y", ys[0], 0);
      chk("midrst ovf", of[0], 0);
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         seen |= ov[0];
      end
      chk("midrst no stale result", seen, 0);
      xact(0, 8'b000011, 2'b01, 8'b00111101, 1'b0);
      for (int g = 1; g < 4; g++)
         for (int xv = 0; xv < 256; xv++)
            for (int m = 0; m < 4; m++) begin
               exp_t e;
               e = model(8, 8'(xv), 2'(m));
               xact(g, 8'(xv), 2'(m), e.y, e.o);
            end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
